frv_dmem_responder: RTL

//  Responder end of the core data memory interface (dmem_*): word-organised

---
 rtl/frv_dmem_responder.sv | 84 ++++++++
 1 files changed

// File: rtl/frv_dmem_responder.sv
// Data memory responder: word SRAM behind the dmem_* request port,
// with fixed and pseudo-random wait states and out-of-range flagging.
module frv_dmem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
  parameter int          DEPTH       = 1024,
  parameter int          WAIT_CYCLES = 0,
  parameter bit          RAND_STALL  = 1'b0,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic        g_clk,
  input  logic        g_reset,
  input  logic        dmem_cen,
  input  logic        dmem_wen,
  input  logic [3:0]  dmem_strb,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  output logic        dmem_stall,
  output logic        dmem_error,
  output logic [31:0] dmem_rdata
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [31:0] SPAN = 32'(DEPTH * 4);
  localparam logic [3:0]  WMAX = 4'(WAIT_CYCLES);

  logic [31:0]   mem [DEPTH];
  logic [3:0]    wcnt;
  logic [15:0]   lfsr;
  logic          fb;
  logic          rstall;
  logic [31:0]   offset;
  logic          in_range;
  logic [AW-1:0] idx;
  logic          done;

  assign offset   = dmem_addr - BASE_ADDR;
  assign in_range = offset < SPAN;
  assign idx      = offset[AW+1:2];

  assign fb     = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign rstall = RAND_STALL & lfsr[0] & lfsr[1];

  // Reset masks the request so a stalled access can never complete into it.
  always_comb begin
    dmem_stall = 1'b0;
    dmem_error = 1'b0;
    dmem_rdata = 32'h0;
    done       = 1'b0;
    if (dmem_cen && !g_reset) begin
      dmem_stall = (wcnt != WMAX) | rstall;
      done       = ~dmem_stall;
    end
    if (done) begin
      dmem_error = ~in_range;
      if (!dmem_wen && in_range)
        dmem_rdata = mem[idx];
    end
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      wcnt <= 4'h0;
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {lfsr[14:0], fb};
      // Hold at the limit while the random stall keeps the access pending.
      if (dmem_cen && dmem_stall) begin
        if (wcnt != WMAX)
          wcnt <= wcnt + 4'h1;
      end else begin
        wcnt <= 4'h0;
      end
    end
  end

  always_ff @(posedge g_clk) begin
    if (done && dmem_wen && in_range) begin
      for (int i = 0; i < 4; i++)
        if (dmem_strb[i])
          mem[idx][8*i +: 8] <= dmem_wdata[8*i +: 8];
    end
  end

endmodule
